// File: rtl/ssp_rx_ctrl_pkg.sv
// ssp_pkg: shared types and constants for the SSP receive controller.
// Holds the main/handoff FSM state enums and sizing constants.
package ssp_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } main_state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_PULSE,
        H_GAP
    } ho_state_t;

    localparam int SSP_SYNC_STAGES = 2;
    localparam int SSP_TO_W        = 16;

endpackage

// File: rtl/ssp_rx_ctrl_if.sv
// ssp_rx_ctrl_if: pins and FIFO handshake of the SSP receive controller.
// slave = controller side, master = pad/FIFO/driver side.
interface ssp_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  RXEN;
    logic                  SSPCLKIN;
    logic                  SSPFSSIN;
    logic                  SSPRXD;
    logic                  SSPRXINTR;
    logic                  EMPTY;
    logic                  ROR_CLR;
    logic [DATA_WIDTH-1:0] RxDATA;
    logic                  ISREADY;
    logic                  SSPRORINTR;
    logic                  SSPRTINTR;
    logic                  BUSY;

    modport slave (
        input  RXEN, SSPCLKIN, SSPFSSIN, SSPRXD,
        input  SSPRXINTR, EMPTY, ROR_CLR,
        output RxDATA, ISREADY, SSPRORINTR,
        output SSPRTINTR, BUSY
    );

    modport master (
        output RXEN, SSPCLKIN, SSPFSSIN, SSPRXD,
        output SSPRXINTR, EMPTY, ROR_CLR,
        input  RxDATA, ISREADY, SSPRORINTR,
        input  SSPRTINTR, BUSY
    );

endinterface

// File: rtl/ssp_rx_ctrl_sync_edge.sv
// ssp_sync_edge: 2-flop synchroniser with rise/fall detect.
// Ports: clk, rst_n, d (async in), q (synced level), rise, fall.
module ssp_sync_edge
    import ssp_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SSP_SYNC_STAGES-1:0] sync;
    logic                       prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SSP_SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SSP_SYNC_STAGES-2:0], d};
            prev <= sync[SSP_SYNC_STAGES-1];
        end
    end

    assign q    = sync[SSP_SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/ssp_rx_ctrl.sv
// ssp_rx_ctrl: SSP receive deserialiser and FIFO handoff sequencer.
// Ports: PCLK, CLEAR_B, bus (ssp_rx_ctrl_if.slave). Option: SSP_RX_TIMEOUT_EN.
module ssp_rx_ctrl
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic          PCLK,
    input  logic          CLEAR_B,
    ssp_rx_ctrl_if.slave  bus
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    main_state_t               state;
    ho_state_t                 hstate;
    logic [CW-1:0]             bit_cnt;
    logic [DATA_WIDTH-2:0]     shift_reg;
    logic [SSP_SYNC_STAGES-1:0] rxd_pipe;
    logic [DATA_WIDTH-1:0]     word;
    logic [DATA_WIDTH-1:0]     rx_data;
    logic                      isready;
    logic                      ror;
    logic                      word_done;
    logic                      clk_lvl, clk_rise, clk_fall;
    logic                      fss_lvl, fss_rise, fss_fall;
    logic                      rxd_d;
    logic                      unused_sync;

    ssp_sync_edge #(.RST_VAL(1'b0)) u_clk_sync (
        .clk   (PCLK),
        .rst_n (CLEAR_B),
        .d     (bus.SSPCLKIN),
        .q     (clk_lvl),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    // Frame select idles high; resetting to 1 avoids a false fall.
    ssp_sync_edge #(.RST_VAL(1'b1)) u_fss_sync (
        .clk   (PCLK),
        .rst_n (CLEAR_B),
        .d     (bus.SSPFSSIN),
        .q     (fss_lvl),
        .rise  (fss_rise),
        .fall  (fss_fall)
    );

    // Data gets the same delay as the clock so it lines up with clk_rise.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) rxd_pipe <= '0;
        else          rxd_pipe <= {rxd_pipe[SSP_SYNC_STAGES-2:0], bus.SSPRXD};
    end

    assign rxd_d     = rxd_pipe[SSP_SYNC_STAGES-1];
    assign word      = {shift_reg, rxd_d};
    assign word_done = (state == SHIFT) && bus.RXEN && !fss_lvl
                     && clk_rise && (bit_cnt == CW'(DATA_WIDTH - 1));

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.RXEN && fss_fall) begin
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bus.RXEN || fss_lvl) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else if (clk_rise) begin
                        shift_reg <= word[DATA_WIDTH-2:0];
                        bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ISREADY: low on load, high one cycle, low one cycle, back to H_IDLE.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            hstate  <= H_IDLE;
            rx_data <= '0;
            isready <= 1'b0;
            ror     <= 1'b0;
        end else begin
            unique case (hstate)
                H_IDLE: begin
                    if (word_done && !bus.SSPRXINTR) begin
                        rx_data <= word;
                        hstate  <= H_PULSE;
                    end
                end
                H_PULSE: begin
                    isready <= 1'b1;
                    hstate  <= H_GAP;
                end
                H_GAP: begin
                    isready <= 1'b0;
                    if (!isready) hstate <= H_IDLE;
                end
                default: hstate <= H_IDLE;
            endcase
            // A new overrun beats a simultaneous clear.
            if (word_done && (bus.SSPRXINTR || hstate != H_IDLE))
                ror <= 1'b1;
            else if (bus.ROR_CLR)
                ror <= 1'b0;
        end
    end

    assign bus.RxDATA     = rx_data;
    assign bus.ISREADY    = isready;
    assign bus.SSPRORINTR = ror;
    assign bus.BUSY       = (state == SHIFT) || (hstate != H_IDLE);

`ifdef SSP_RX_TIMEOUT_EN
    logic [SSP_TO_W-1:0] to_cnt;

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B)
            to_cnt <= '0;
        else if (bus.EMPTY || clk_rise || hstate != H_IDLE)
            to_cnt <= '0;
        else if (to_cnt != '1)
            to_cnt <= to_cnt + 1'b1;
    end

    assign bus.SSPRTINTR = (to_cnt >= SSP_TO_W'(TIMEOUT_CYCLES - 1));
    assign unused_sync   = clk_lvl ^ clk_fall ^ fss_rise;
`else
    assign bus.SSPRTINTR = 1'b0;
    assign unused_sync   = ^{clk_lvl, clk_fall, fss_rise,
                             bus.EMPTY, (TIMEOUT_CYCLES == 0)};
`endif

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// tb_ssp_rx_ctrl: table-driven and scoreboard bench for ssp_rx_ctrl.
// Drives/samples on PCLK falling edges; RTL state changes on rising.
module tb_ssp_rx_ctrl;

    logic PCLK;
    logic CLEAR_B;

    ssp_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    ssp_rx_ctrl #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .PCLK    (PCLK),
        .CLEAR_B (CLEAR_B),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;
    logic prev_isr = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard: every ISREADY pulse must be one cycle wide and carry
    // the next expected word.
    always @(negedge PCLK) begin
        if (bus.ISREADY) begin
            pulses++;
            chk("isready_width", {31'd0, prev_isr}, 32'd0);
            if (exp_q.size() == 0)
                chk("unexpected_push", {24'd0, bus.RxDATA}, 32'hFFFF_FFFF);
            else
                chk("push_data", {24'd0, bus.RxDATA},
                    {24'd0, exp_q.pop_front()});
        end
        prev_isr = bus.ISREADY;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // act: 0 none, 1 ROR_CLR in the word-complete cycle, 2 CLEAR_B in H_PULSE
    task automatic send_bit(input logic b, input int act);
        bus.SSPCLKIN = 1'b0;
        bus.SSPRXD   = b;
        repeat (3) @(negedge PCLK);
        bus.SSPCLKIN = 1'b1;
        if (act == 1) begin
            repeat (2) @(negedge PCLK);
            bus.ROR_CLR = 1'b1;
            @(negedge PCLK);
            bus.ROR_CLR = 1'b0;
        end else if (act == 2) begin
            repeat (3) @(negedge PCLK);
            CLEAR_B = 1'b0;
            #1;
            chk("clr_isready", {31'd0, bus.ISREADY}, 32'd0);
            chk("clr_rxdata", {24'd0, bus.RxDATA}, 32'd0);
            chk("clr_busy", {31'd0, bus.BUSY}, 32'd0);
        end else begin
            repeat (3) @(negedge PCLK);
        end
    endtask

    task automatic send_frame(input logic [15:0] data, input int n,
                              input int act);
        bus.SSPFSSIN = 1'b0;
        repeat (3) @(negedge PCLK);
        for (int i = n - 1; i >= 0; i--)
            send_bit(data[i], (i == 0) ? act : 0);
        bus.SSPCLKIN = 1'b0;
        repeat (3) @(negedge PCLK);
        bus.SSPFSSIN = 1'b1;
        repeat (12) @(negedge PCLK);
    endtask

    task automatic ror_clear();
        bus.ROR_CLR = 1'b1;
        @(negedge PCLK);
        bus.ROR_CLR = 1'b0;
        @(negedge PCLK);
    endtask

    typedef struct {
        logic [7:0] word;
        logic       full;
        logic [7:0] exp_rx;
        logic       exp_ror;
    } vec_t;

    vec_t vecs[6];
    int   p0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 8'hA5, 1'b1};
        vecs[2] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'h7E, 1'b0, 8'h7E, 1'b0};

        CLEAR_B       = 1'b0;
        bus.RXEN      = 1'b1;
        bus.SSPCLKIN  = 1'b0;
        bus.SSPFSSIN  = 1'b1;
        bus.SSPRXD    = 1'b0;
        bus.SSPRXINTR = 1'b0;
        bus.EMPTY     = 1'b1;
        bus.ROR_CLR   = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_rxdata", {24'd0, bus.RxDATA}, 32'd0);
        chk("rst_isready", {31'd0, bus.ISREADY}, 32'd0);
        chk("rst_ror", {31'd0, bus.SSPRORINTR}, 32'd0);
        chk("rst_rt", {31'd0, bus.SSPRTINTR}, 32'd0);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        CLEAR_B = 1'b1;
        repeat (4) @(negedge PCLK);

        foreach (vecs[k]) begin
            p0 = pulses;
            bus.SSPRXINTR = vecs[k].full;
            if (!vecs[k].full) exp_q.push_back(vecs[k].word);
            send_frame({8'd0, vecs[k].word}, 8, 0);
            bus.SSPRXINTR = 1'b0;
            chk($sformatf("vec%0d_pushes", k), pulses - p0,
                vecs[k].full ? 0 : 1);
            chk($sformatf("vec%0d_rx", k), {24'd0, bus.RxDATA},
                {24'd0, vecs[k].exp_rx});
            chk($sformatf("vec%0d_ror", k), {31'd0, bus.SSPRORINTR},
                {31'd0, vecs[k].exp_ror});
            chk($sformatf("vec%0d_busy", k), {31'd0, bus.BUSY}, 32'd0);
            ror_clear();
            chk($sformatf("vec%0d_ror_clr", k), {31'd0, bus.SSPRORINTR},
                32'd0);
        end

        // ROR_CLR coinciding with a new overrun: set must win.
        bus.SSPRXINTR = 1'b1;
        send_frame(16'h0055, 8, 1);
        bus.SSPRXINTR = 1'b0;
        chk("ror_set_wins", {31'd0, bus.SSPRORINTR}, 32'd1);
        ror_clear();
        chk("ror_clr2", {31'd0, bus.SSPRORINTR}, 32'd0);

        // Back-to-back words in one frame at the minimum clock period.
        p0 = pulses;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(16'h3CC3, 16, 0);
        chk("b2b_pushes", pulses - p0, 2);
        chk("b2b_ror", {31'd0, bus.SSPRORINTR}, 32'd0);
        chk("b2b_rx", {24'd0, bus.RxDATA}, 32'hC3);

        // Partial word is discarded, next full frame lands cleanly.
        p0 = pulses;
        send_frame(16'h0015, 5, 0);
        chk("part_pushes", pulses - p0, 0);
        chk("part_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("part_ror", {31'd0, bus.SSPRORINTR}, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(16'h0081, 8, 0);
        chk("after_part_rx", {24'd0, bus.RxDATA}, 32'h81);
        chk("after_part_pushes", pulses - p0, 1);

        bus.EMPTY = 1'b0;
`ifdef SSP_RX_TIMEOUT_EN
        repeat (30) @(negedge PCLK);
        chk("rt_before", {31'd0, bus.SSPRTINTR}, 32'd0);
        @(negedge PCLK);
        chk("rt_rise", {31'd0, bus.SSPRTINTR}, 32'd1);
        bus.EMPTY = 1'b1;
        @(negedge PCLK);
        chk("rt_fall", {31'd0, bus.SSPRTINTR}, 32'd0);
`else
        repeat (40) @(negedge PCLK);
        chk("rt_tied", {31'd0, bus.SSPRTINTR}, 32'd0);
        bus.EMPTY = 1'b1;
`endif

        // Reset asserted while the handoff sits in H_PULSE.
        p0 = pulses;
        send_frame(16'h00E7, 8, 2);
        CLEAR_B = 1'b1;
        repeat (10) @(negedge PCLK);
        chk("clr_pushes", pulses - p0, 0);
        chk("clr_ror", {31'd0, bus.SSPRORINTR}, 32'd0);
        chk("clr_rx_held", {24'd0, bus.RxDATA}, 32'd0);

        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
